// File: rtl/simax_pkg.sv
// Shared definitions for the SIMAX matrix-vector engine.
//   state_e      : engine FSM encoding (IDLE, COMPUTE, WAIT_NEXT, OUTPUT)
//   clog2_min1() : address width helper, never returns less than 1
//   sat_add()    : saturating signed add, result clamped to an acc_w-bit range
//   sat_ovf()    : flags that the same add would have clamped
// Operands are passed sign-extended to SAT_W bits so a single function
// serves any accumulator width up to SAT_W-1.
package simax_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPUTE   = 2'd1,
    ST_WAIT_NEXT = 2'd2,
    ST_OUTPUT    = 2'd3
  } state_e;

  localparam int unsigned SAT_W = 64;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w == 0) ? 1 : w;
  endfunction

  // Sum is formed one bit wider than the operands so it cannot wrap.
  function automatic logic signed [SAT_W:0] wide_sum(input logic signed [SAT_W-1:0] a,
                                                     input logic signed [SAT_W-1:0] b);
    logic signed [SAT_W:0] s;
    s = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    return s;
  endfunction

  function automatic logic signed [SAT_W:0] sat_hi(input int unsigned acc_w);
    logic signed [SAT_W:0] one;
    one    = '0;
    one[0] = 1'b1;
    return (one <<< (acc_w - 1)) - one;
  endfunction

  function automatic logic signed [SAT_W:0] sat_lo(input int unsigned acc_w);
    logic signed [SAT_W:0] one;
    one    = '0;
    one[0] = 1'b1;
    return -(one <<< (acc_w - 1));
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_add(input logic signed [SAT_W-1:0] a,
                                                      input logic signed [SAT_W-1:0] b,
                                                      input int unsigned acc_w);
    logic signed [SAT_W:0] s;
    logic signed [SAT_W:0] r;
    s = wide_sum(a, b);
    r = s;
    if (s > sat_hi(acc_w)) r = sat_hi(acc_w);
    else if (s < sat_lo(acc_w)) r = sat_lo(acc_w);
    return r[SAT_W-1:0];
  endfunction

  function automatic logic sat_ovf(input logic signed [SAT_W-1:0] a,
                                   input logic signed [SAT_W-1:0] b,
                                   input int unsigned acc_w);
    logic signed [SAT_W:0] s;
    s = wide_sum(a, b);
    return (s > sat_hi(acc_w)) || (s < sat_lo(acc_w));
  endfunction

endpackage

// File: rtl/simax_mac_lane.sv
// One output row of the SIMAX engine: a COLS-entry signed weight file,
// a saturating multiply-accumulate and a sticky saturation flag.
//   wr_en/wr_col/wr_data : weight write (columns >= COLS are dropped)
//   col_sel/x_elem       : current column index and input element
//   acc_clr              : clear accumulator and flag (start of tile)
//   mac_en               : acc <= sat(acc + W[col_sel]*x_elem)
//   acc_o/sat_o          : accumulator value and sticky saturation flag
module simax_mac_lane
  import simax_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned COLS  = 8,
  parameter int unsigned ACC_W = 20,
  parameter int unsigned COL_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [COL_W-1:0]        wr_col,
  input  logic signed [DW-1:0]    wr_data,
  input  logic [COL_W-1:0]        col_sel,
  input  logic signed [DW-1:0]    x_elem,
  input  logic                    acc_clr,
  input  logic                    mac_en,
  output logic signed [ACC_W-1:0] acc_o,
  output logic                    sat_o
);

  logic signed [DW-1:0]    w_q [COLS];
  logic signed [DW-1:0]    w_d [COLS];
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    sat_q, sat_d;
  logic signed [2*DW-1:0]  prod;

  assign prod = w_q[col_sel] * x_elem;

  always_comb begin
    w_d = w_q;
    if (wr_en && (32'(wr_col) < COLS)) w_d[wr_col] = wr_data;
  end

  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (acc_clr) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (mac_en) begin
      acc_d = ACC_W'(sat_add(SAT_W'(acc_q), SAT_W'(prod), ACC_W));
      sat_d = sat_q | sat_ovf(SAT_W'(acc_q), SAT_W'(prod), ACC_W);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < COLS; i++) w_q[i] <= '0;
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      w_q   <= w_d;
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign acc_o = acc_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/simax_mv_engine.sv
// SIMAX matrix-vector engine: y[r] = sum_c W[r][c]*x[c], one column per
// cycle, saturating to ACC_W bits, optionally accumulated over an
// x_last-terminated tile.
//   cfg_*        : weight write handshake, cfg_addr = {row, col}
//   x_*          : input vector stream, x_last marks the end of a tile
//   res_*        : result stream, result_flat row r at [r*ACC_W +: ACC_W]
//   res_sat      : per-row sticky saturation flag of the current result
//   busy         : engine not idle
module simax_mv_engine
  import simax_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 8,
  parameter int unsigned ACC_W    = 20,
  parameter int unsigned ACCUM_EN = 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          cfg_valid,
  output logic                                          cfg_ready,
  input  logic [clog2_min1(ROWS)+clog2_min1(COLS)-1:0]  cfg_addr,
  input  logic [DW-1:0]                                 cfg_data,
  input  logic                                          x_valid,
  output logic                                          x_ready,
  input  logic [COLS*DW-1:0]                            x_vector_flat,
  input  logic                                          x_last,
  output logic                                          res_valid,
  input  logic                                          res_ready,
  output logic [ROWS*ACC_W-1:0]                         result_flat,
  output logic [ROWS-1:0]                               res_sat,
  output logic                                          busy
);

  localparam int unsigned ROW_W = clog2_min1(ROWS);
  localparam int unsigned COL_W = clog2_min1(COLS);
  localparam int unsigned CNT_W = COL_W;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [COLS*DW-1:0]   x_q, x_d;
  logic                 last_q, last_d;
  logic                 acc_clr, mac_en, cfg_fire;
  logic [ROW_W-1:0]     cfg_row;
  logic [COL_W-1:0]     cfg_col;
  logic signed [DW-1:0] x_sel;

  assign cfg_row  = cfg_addr[ROW_W+COL_W-1 -: ROW_W];
  assign cfg_col  = cfg_addr[COL_W-1:0];
  assign cfg_fire = cfg_valid && cfg_ready;
  assign x_sel    = x_q[cnt_q*DW +: DW];
  assign busy     = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    last_d    = last_q;
    cfg_ready = 1'b0;
    x_ready   = 1'b0;
    res_valid = 1'b0;
    acc_clr   = 1'b0;
    mac_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        x_ready   = 1'b1;
        if (x_valid) begin
          x_d     = x_vector_flat;
          last_d  = x_last;
          cnt_d   = '0;
          acc_clr = 1'b1;
          state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        mac_en = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(COLS - 1)) begin
          cnt_d   = '0;
          state_d = ((ACCUM_EN == 0) || last_q) ? ST_OUTPUT : ST_WAIT_NEXT;
        end
      end
      ST_WAIT_NEXT: begin
        x_ready = 1'b1;
        if (x_valid) begin
          x_d     = x_vector_flat;
          last_d  = x_last;
          cnt_d   = '0;
          state_d = ST_COMPUTE;
        end
      end
      ST_OUTPUT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      last_q  <= last_d;
    end
  end

  // Rows beyond ROWS have no lane, so out-of-range writes simply vanish.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic signed [ACC_W-1:0] acc;
    simax_mac_lane #(
      .DW   (DW),
      .COLS (COLS),
      .ACC_W(ACC_W),
      .COL_W(COL_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (cfg_fire && (cfg_row == ROW_W'(r))),
      .wr_col (cfg_col),
      .wr_data(cfg_data),
      .col_sel(cnt_q),
      .x_elem (x_sel),
      .acc_clr(acc_clr),
      .mac_en (mac_en),
      .acc_o  (acc),
      .sat_o  (res_sat[r])
    );
    assign result_flat[r*ACC_W +: ACC_W] = acc;
  end

endmodule

// File: tb/tb_simax_mv_engine.sv
// Directed bench for simax_mv_engine. DUT A: ROWS=4, COLS=8, ACC_W=20,
// ACCUM_EN=1. DUT B: ROWS=3, COLS=8, ACC_W=16, ACCUM_EN=0 (saturation,
// out-of-range row writes, x_last ignored).
module tb_simax_mv_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        a_cfg_valid, a_cfg_ready, a_x_valid, a_x_ready, a_x_last;
  logic        a_res_valid, a_res_ready, a_busy;
  logic [4:0]  a_cfg_addr;
  logic [7:0]  a_cfg_data;
  logic [63:0] a_x_vec;
  logic [79:0] a_result;
  logic [3:0]  a_res_sat;

  logic        b_cfg_valid, b_cfg_ready, b_x_valid, b_x_ready, b_x_last;
  logic        b_res_valid, b_res_ready, b_busy;
  logic [4:0]  b_cfg_addr;
  logic [7:0]  b_cfg_data;
  logic [63:0] b_x_vec;
  logic [47:0] b_result;
  logic [2:0]  b_res_sat;

  simax_mv_engine #(.DW(8), .ROWS(4), .COLS(8), .ACC_W(20), .ACCUM_EN(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(a_cfg_valid), .cfg_ready(a_cfg_ready), .cfg_addr(a_cfg_addr), .cfg_data(a_cfg_data),
    .x_valid(a_x_valid), .x_ready(a_x_ready), .x_vector_flat(a_x_vec), .x_last(a_x_last),
    .res_valid(a_res_valid), .res_ready(a_res_ready), .result_flat(a_result),
    .res_sat(a_res_sat), .busy(a_busy)
  );

  simax_mv_engine #(.DW(8), .ROWS(3), .COLS(8), .ACC_W(16), .ACCUM_EN(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready), .cfg_addr(b_cfg_addr), .cfg_data(b_cfg_data),
    .x_valid(b_x_valid), .x_ready(b_x_ready), .x_vector_flat(b_x_vec), .x_last(b_x_last),
    .res_valid(b_res_valid), .res_ready(b_res_ready), .result_flat(b_result),
    .res_sat(b_res_sat), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  function automatic logic [63:0] row_val(input bit sel, input int r);
    logic signed [15:0] b16;
    logic signed [19:0] a20;
    if (sel) begin
      b16 = b_result[r*16 +: 16];
      return 64'(b16);
    end
    a20 = a_result[r*20 +: 20];
    return 64'(a20);
  endfunction

  task automatic check_rows(input string tag, input bit sel, input int e0, input int e1,
                            input int e2, input int e3, input logic [3:0] esat);
    int e[4];
    int nrows;
    e = '{e0, e1, e2, e3};
    nrows = sel ? 3 : 4;
    for (int r = 0; r < nrows; r++)
      check($sformatf("%s_row%0d", tag, r), row_val(sel, r), 64'(e[r]));
    check({tag, "_sat"}, sel ? 64'(b_res_sat) : 64'(a_res_sat), 64'(esat));
  endtask

  task automatic cfg_write(input bit sel, input int row, input int col, input int data);
    int k;
    @(negedge clk);
    if (sel) begin
      b_cfg_valid = 1'b1; b_cfg_addr = {row[1:0], col[2:0]}; b_cfg_data = data[7:0];
    end else begin
      a_cfg_valid = 1'b1; a_cfg_addr = {row[1:0], col[2:0]}; a_cfg_data = data[7:0];
    end
    k = 0;
    while (!(sel ? b_cfg_ready : a_cfg_ready) && k < 30) begin @(negedge clk); k++; end
    if (k == 30) check("cfg_ready_timeout", 64'(sel ? b_cfg_ready : a_cfg_ready), 64'd1);
    @(posedge clk); #1;
    a_cfg_valid = 1'b0;
    b_cfg_valid = 1'b0;
  endtask

  task automatic send_x(input bit sel, input logic [63:0] vec, input logic last);
    int k;
    @(negedge clk);
    if (sel) begin b_x_valid = 1'b1; b_x_vec = vec; b_x_last = last; end
    else     begin a_x_valid = 1'b1; a_x_vec = vec; a_x_last = last; end
    k = 0;
    while (!(sel ? b_x_ready : a_x_ready) && k < 30) begin @(negedge clk); k++; end
    if (k == 30) check("x_ready_timeout", 64'(sel ? b_x_ready : a_x_ready), 64'd1);
    @(posedge clk); #1;
    a_x_valid = 1'b0;
    b_x_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; returns edges until the consuming edge.
  task automatic wait_res(input bit sel, output int lat);
    int edges;
    edges = 0;
    while (!(sel ? b_res_valid : a_res_valid) && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    if (edges == 40) check("res_valid_timeout", 64'(sel ? b_res_valid : a_res_valid), 64'd1);
    lat = edges + 1;
  endtask

  task automatic take_res(input bit sel);
    @(negedge clk);
    if (sel) b_res_ready = 1'b1; else a_res_ready = 1'b1;
    @(posedge clk); #1;
    a_res_ready = 1'b0;
    b_res_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] v;
    int lat;

    a_cfg_valid = 0; a_cfg_addr = '0; a_cfg_data = '0; a_x_valid = 0; a_x_vec = '0;
    a_x_last = 0; a_res_ready = 0;
    b_cfg_valid = 0; b_cfg_addr = '0; b_cfg_data = '0; b_x_valid = 0; b_x_vec = '0;
    b_x_last = 0; b_res_ready = 0;

    // Reset state
    #23;
    check("rst_cfg_ready", 64'(a_cfg_ready), 64'd1);
    check("rst_x_ready",   64'(a_x_ready),   64'd1);
    check("rst_res_valid", 64'(a_res_valid), 64'd0);
    check("rst_busy",      64'(a_busy),      64'd0);
    check("rst_result",    a_result[63:0],   64'd0);
    check("rst_sat",       64'(a_res_sat),   64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Identity weights, x = 1..8 -> 1,2,3,4; latency and hold behaviour
    for (int r = 0; r < 4; r++) cfg_write(0, r, r, 1);
    for (int c = 0; c < 8; c++) v[c*8 +: 8] = 8'(c + 1);
    send_x(0, v, 1'b1);
    check("compute_busy",      64'(a_busy),      64'd1);
    check("compute_cfg_ready", 64'(a_cfg_ready), 64'd0);
    check("compute_x_ready",   64'(a_x_ready),   64'd0);
    wait_res(0, lat);
    check("latency", 64'(lat), 64'd9);
    check_rows("ident", 0, 1, 2, 3, 4, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_res_valid", 64'(a_res_valid), 64'd1);
      check("hold_x_ready",   64'(a_x_ready),   64'd0);
      check_rows("hold", 0, 1, 2, 3, 4, 4'b0000);
    end
    take_res(0);
    check("post_res_valid", 64'(a_res_valid), 64'd0);
    check("post_x_ready",   64'(a_x_ready),   64'd1);
    check("post_busy",      64'(a_busy),      64'd0);

    // Two-vector tile, all W=2: 8*6 + 8*(-2) = 32
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) cfg_write(0, r, c, 2);
    v = {8{8'd3}};
    send_x(0, v, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("tile_no_res",    64'(a_res_valid), 64'd0);
      check("tile_cfg_ready", 64'(a_cfg_ready), 64'd0);
    end
    check("wait_x_ready", 64'(a_x_ready), 64'd1);
    check("wait_busy",    64'(a_busy),    64'd1);
    v = {8{8'hFF}};
    send_x(0, v, 1'b1);
    check("tile2_cfg_ready", 64'(a_cfg_ready), 64'd0);
    wait_res(0, lat);
    check_rows("accum", 0, 32, 32, 32, 32, 4'b0000);
    take_res(0);

    // Same-cycle cfg write W[0][0]=5 and x accept with x[0]=2
    @(negedge clk);
    a_cfg_valid = 1'b1; a_cfg_addr = 5'b00000; a_cfg_data = 8'd5;
    a_x_valid = 1'b1; a_x_vec = 64'd2; a_x_last = 1'b1;
    check("same_cfg_ready", 64'(a_cfg_ready), 64'd1);
    check("same_x_ready",   64'(a_x_ready),   64'd1);
    @(posedge clk); #1;
    a_cfg_valid = 1'b0; a_x_valid = 1'b0;
    wait_res(0, lat);
    check_rows("same", 0, 10, 4, 4, 4, 4'b0000);
    take_res(0);

    // Asynchronous reset mid-COMPUTE, then weights must be cleared
    for (int c = 0; c < 8; c++) v[c*8 +: 8] = 8'(c + 1);
    send_x(0, v, 1'b1);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy",      64'(a_busy),      64'd0);
    check("arst_res_valid", 64'(a_res_valid), 64'd0);
    check("arst_cfg_ready", 64'(a_cfg_ready), 64'd1);
    check("arst_x_ready",   64'(a_x_ready),   64'd1);
    @(negedge clk); rst_n = 1'b1;
    send_x(0, v, 1'b1);
    wait_res(0, lat);
    check_rows("postrst", 0, 0, 0, 0, 0, 4'b0000);
    take_res(0);

    // DUT B: out-of-range row writes dropped; x_last=0 still yields a result
    @(negedge clk);
    check("oor_cfg_ready", 64'(b_cfg_ready), 64'd1);
    for (int c = 0; c < 8; c++) cfg_write(1, 3, c, 7);
    v = {8{8'd1}};
    send_x(1, v, 1'b0);
    wait_res(1, lat);
    check_rows("oor", 1, 0, 0, 0, 0, 4'b0000);
    take_res(1);

    // Positive saturation: 8*127*127 clamps to 32767
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 8; c++) cfg_write(1, r, c, 127);
    v = {8{8'd127}};
    send_x(1, v, 1'b0);
    wait_res(1, lat);
    check_rows("satpos", 1, 32767, 32767, 32767, 0, 4'b0111);
    take_res(1);

    // Negative saturation: 8*(-128)*127 clamps to -32768
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 8; c++) cfg_write(1, r, c, -128);
    send_x(1, v, 1'b1);
    wait_res(1, lat);
    check_rows("satneg", 1, -32768, -32768, -32768, 0, 4'b0111);
    take_res(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
